// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline stages.
package arm_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} with push/pop/flush and a head output.
//
// state | meaning
// EMPTY | no entries; head output reads NOP
// ONE   | head valid, tail unused
// FULL  | head and tail valid
module fetch_buffer
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic        valid,
  output logic [1:0]  occupancy,
  output logic [31:0] head_instr,
  output logic [31:0] head_pc
);

  fetch_state_t state;
  fetch_entry_t head;
  fetch_entry_t tail;
  fetch_entry_t in_entry;
  logic         do_pop;

  assign in_entry = '{instr: push_instr, pc: push_pc};
  assign do_pop   = pop && (state != EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      // head is left in place so its pc stays visible while empty
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, do_pop})
            2'b10: begin
              tail  <= in_entry;
              state <= FULL;
            end
            2'b01: state <= EMPTY;
            2'b11: head <= in_entry;
            default: ;
          endcase
        end
        FULL: begin
          if (do_pop) begin
            head <= tail;
            if (push) tail <= in_entry;
            else      state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid      = (state != EMPTY);
  assign occupancy  = state;
  assign head_instr = valid ? head.instr : NOP_INSTR;
  assign head_pc    = head.pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, +4 / redirect mux, and the output buffer
// presented to IF/ID through a valid/ready handshake.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_instr,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc_plus_4,
  output logic [31:0]           pc_current
);

  logic [31:0] pc;
  logic [1:0]  occupancy;
  logic        pop;
  logic        fetch_en;
  logic        push;

  assign pop      = out_valid && out_ready;
  assign fetch_en = (occupancy != FULL) || pop;
  // a redirect discards whatever word is being read this cycle
  assign push     = fetch_en && !branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target & 32'hFFFF_FFFC;
    end else if (fetch_en) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_instr (imem_instr),
    .push_pc    (pc),
    .pop        (pop),
    .flush      (branch_taken),
    .valid      (out_valid),
    .occupancy  (occupancy),
    .head_instr (out_instr),
    .head_pc    (out_pc)
  );

  assign imem_addr     = pc[ADDR_WIDTH-1:0];
  assign pc_current    = pc;
  assign out_pc_plus_4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect, wrap and async reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] pc_current;

  logic        reset2;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_instr2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic [31:0] out_pc_plus_42;
  logic [31:0] pc_current2;

  int n_checks;
  int n_errors;

  // memory word at byte address a is E000_00aa
  assign imem_instr  = 32'hE000_0000 | {24'h0, imem_addr};
  assign imem_instr2 = 32'hE000_0000 | {24'h0, imem_addr2};

  fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .pc_current    (pc_current)
  );

  fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(32'h0000_00FC)) dut_wrap (
    .clk           (clk),
    .reset         (reset2),
    .imem_addr     (imem_addr2),
    .imem_instr    (imem_instr2),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .out_valid     (out_valid2),
    .out_ready     (1'b1),
    .out_instr     (out_instr2),
    .out_pc        (out_pc2),
    .out_pc_plus_4 (out_pc_plus_42),
    .pc_current    (pc_current2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    reset2        = 1'b0;
    out_ready     = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    // reset held 3 cycles
    repeat (3) step();
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc4", out_pc_plus_4, 32'h4);
    check("rst_pc_cur", pc_current, 32'h0);
    check("rst_addr", {24'h0, imem_addr}, 32'h0);

    // streaming with out_ready = 1
    reset = 1'b1;
    step();
    check("s1_valid", {31'h0, out_valid}, 32'h1);
    check("s1_instr0", out_instr, 32'hE000_0000);
    check("s1_pc0", out_pc, 32'h0);
    check("s1_pc4_0", out_pc_plus_4, 32'h4);
    step();
    check("s1_instr1", out_instr, 32'hE000_0004);
    check("s1_pc1", out_pc, 32'h4);
    step();
    check("s1_instr2", out_instr, 32'hE000_0008);
    check("s1_pc2", out_pc, 32'h8);
    step();
    check("s1_instr3", out_instr, 32'hE000_000C);
    check("s1_pc3", out_pc, 32'hC);
    check("s1_pc_cur", pc_current, 32'h10);

    // redirect at PC 16 to 7 -> 4
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0007;
    step();
    branch_taken  = 1'b0;
    check("br_pc_cur", pc_current, 32'h4);
    check("br_bubble", {31'h0, out_valid}, 32'h0);
    check("br_bubble_instr", out_instr, 32'h0);
    step();
    check("br_valid", {31'h0, out_valid}, 32'h1);
    check("br_instr", out_instr, 32'hE000_0004);
    check("br_pc", out_pc, 32'h4);
    step();
    check("br_next_pc", out_pc, 32'h8);

    // stall from reset release
    reset     = 1'b0;
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("st_pc_cur1", pc_current, 32'h4);
    step();
    check("st_pc_cur2", pc_current, 32'h8);
    check("st_head2", out_instr, 32'hE000_0000);
    step();
    step();
    check("st_pc_cur4", pc_current, 32'h8);
    check("st_head4", out_instr, 32'hE000_0000);
    check("st_head4_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    #1;
    check("dr_head0", out_instr, 32'hE000_0000);
    step();
    check("dr_head1", out_instr, 32'hE000_0004);
    check("dr_pc1", out_pc, 32'h4);
    step();
    check("dr_head2", out_instr, 32'hE000_0008);
    step();
    check("dr_head3_pc", out_pc, 32'hC);
    check("dr_pc_cur", pc_current, 32'h14);

    // hold while FULL, then branch with the head accepted
    out_ready = 1'b0;
    step();
    check("hold_pc", out_pc, 32'hC);
    check("hold_pc_cur", pc_current, 32'h14);
    out_ready     = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0020;
    #1;
    check("bf_head_valid", {31'h0, out_valid}, 32'h1);
    check("bf_head_pc", out_pc, 32'hC);
    step();
    branch_taken = 1'b0;
    check("bf_bubble", {31'h0, out_valid}, 32'h0);
    check("bf_pc_cur", pc_current, 32'h20);
    step();
    check("bf_valid", {31'h0, out_valid}, 32'h1);
    check("bf_instr", out_instr, 32'hE000_0020);
    check("bf_pc", out_pc, 32'h20);
    step();
    check("bf_next_pc", out_pc, 32'h24);

    // async reset between edges while FULL
    out_ready = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", {31'h0, out_valid}, 32'h0);
    check("ar_instr", out_instr, 32'h0);
    check("ar_pc_cur", pc_current, 32'h0);
    out_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("ar_instr0", out_instr, 32'hE000_0000);
    check("ar_pc0", out_pc, 32'h0);
    step();
    check("ar_instr1", out_instr, 32'hE000_0004);
    check("ar_pc1", out_pc, 32'h4);

    // address wrap from RESET_PC = FC
    check("wr_rst_addr", {24'h0, imem_addr2}, 32'hFC);
    check("wr_rst_pc", pc_current2, 32'hFC);
    reset2 = 1'b1;
    step();
    check("wr_addr", {24'h0, imem_addr2}, 32'h0);
    check("wr_pc_cur", pc_current2, 32'h100);
    check("wr_instr", out_instr2, 32'hE000_00FC);
    check("wr_pc", out_pc2, 32'hFC);
    check("wr_pc4", out_pc_plus_42, 32'h100);
    step();
    check("wr_instr_next", out_instr2, 32'hE000_0000);
    check("wr_pc_next", out_pc2, 32'h100);
    check("wr_valid_next", {31'h0, out_valid2}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
